// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 720p raster timing constants, RGB222 colours and a window helper
//
// Purpose : shared constants for the VGA/HDMI raster path.
//   H_* / V_*        : 1280x720@60 timing, in pixel clocks and lines
//   H_TOTAL, V_TOTAL : full line length and full frame height
//   CNT_W, RGB_W     : counter and pixel widths
//   RGB_*            : RGB222 colour constants ({r[1:0], g[1:0], b[1:0]})
//   in_range()       : inclusive range test of a counter value
package vga_timing_pkg;

    localparam int H_SYNC  = 40;
    localparam int H_BACK  = 220;
    localparam int H_DISP  = 1280;
    localparam int H_FRONT = 110;
    localparam int V_SYNC  = 5;
    localparam int V_BACK  = 20;
    localparam int V_DISP  = 720;
    localparam int V_FRONT = 5;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam int CNT_W = 11;
    localparam int RGB_W = 6;

    localparam logic [RGB_W-1:0] RGB_BLACK = 6'b00_00_00;
    localparam logic [RGB_W-1:0] RGB_WHITE = 6'b11_11_11;
    localparam logic [RGB_W-1:0] RGB_RED   = 6'b11_00_00;
    localparam logic [RGB_W-1:0] RGB_GREEN = 6'b00_11_00;
    localparam logic [RGB_W-1:0] RGB_BLUE  = 6'b00_00_11;

    // Comparing as int keeps the bounds free of width truncation; the
    // counter is zero-extended so no negative values can appear.
    function automatic logic in_range(logic [CNT_W-1:0] value, int lo, int hi);
        return (int'(value) >= lo) && (int'(value) <= hi);
    endfunction

endpackage

// File: rtl/vga_driver_if.sv
// rtl/vga_driver_if.sv - pixel-source request/return and sync output bundle
//
// Purpose : groups the pixel request/return path and the raster outputs.
//   pixel_data  : RGB222 from the pixel source, PIX_LAT cycles after its request
//   pixel_xpos  : requested column
//   pixel_ypos  : requested row
//   data_req    : pixel_xpos/pixel_ypos hold a valid request
//   vga_hs/vs   : horizontal / vertical sync
//   vga_de      : active video
//   vga_rgb     : RGB222 out, black while vga_de is low
//   frame_start : one-cycle pulse per frame
// Modports: master = vga_driver side, slave = pixel source / PHY side.
interface vga_driver_if;
    import vga_timing_pkg::CNT_W;
    import vga_timing_pkg::RGB_W;

    logic [RGB_W-1:0] pixel_data;
    logic [CNT_W-1:0] pixel_xpos;
    logic [CNT_W-1:0] pixel_ypos;
    logic             data_req;
    logic             vga_hs;
    logic             vga_vs;
    logic             vga_de;
    logic [RGB_W-1:0] vga_rgb;
    logic             frame_start;

    modport master (
        input  pixel_data,
        output pixel_xpos, pixel_ypos, data_req,
        output vga_hs, vga_vs, vga_de, vga_rgb, frame_start
    );

    modport slave (
        output pixel_data,
        input  pixel_xpos, pixel_ypos, data_req,
        input  vga_hs, vga_vs, vga_de, vga_rgb, frame_start
    );

endinterface

// File: rtl/vga_timing_cnt.sv
// rtl/vga_timing_cnt.sv - horizontal/vertical raster position counters
//
// Purpose : h_cnt runs 0..H_TOTAL-1 every line; v_cnt advances on each
//           h_cnt wrap and runs 0..V_TOTAL-1 every frame.
// Ports   :
//   pixel_clk : pixel clock
//   sys_rst   : synchronous active-high reset, returns both counters to 0
//   h_cnt     : pixel position within the line
//   v_cnt     : line position within the frame
module vga_timing_cnt #(
    parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_timing_pkg::V_TOTAL
) (
    input  logic                             pixel_clk,
    input  logic                             sys_rst,
    output logic [vga_timing_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_timing_pkg::CNT_W-1:0] v_cnt
);
    import vga_timing_pkg::CNT_W;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_driver.sv
// rtl/vga_driver.sv - raster timing, pixel requests and aligned RGB222 output
//
// Purpose : generates sync/data-enable timing, requests pixels from the
//           pixel source PIX_LAT cycles ahead of display, and registers the
//           returned data together with the sync outputs.
// Ports   :
//   pixel_clk : pixel clock
//   sys_rst   : synchronous active-high reset
//   vif       : vga_driver_if.master (pixel request/return, sync outputs)
module vga_driver #(
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BACK  = vga_timing_pkg::H_BACK,
    parameter int H_DISP  = vga_timing_pkg::H_DISP,
    parameter int H_FRONT = vga_timing_pkg::H_FRONT,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BACK  = vga_timing_pkg::V_BACK,
    parameter int V_DISP  = vga_timing_pkg::V_DISP,
    parameter int V_FRONT = vga_timing_pkg::V_FRONT,
    parameter bit H_POL   = 1'b1,
    parameter bit V_POL   = 1'b1,
    parameter int PIX_LAT = 1
) (
    input  logic         pixel_clk,
    input  logic         sys_rst,
    vga_driver_if.master vif
);
    import vga_timing_pkg::CNT_W;
    import vga_timing_pkg::RGB_BLACK;
    import vga_timing_pkg::in_range;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int H_ACT   = H_SYNC + H_BACK;
    localparam int V_ACT   = V_SYNC + V_BACK;

    // Requests lead the displayed column by PIX_LAT so the returned data
    // lands exactly on the de_raw window.
    localparam int               REQ_H_LO = H_ACT - PIX_LAT;
    localparam int               REQ_H_HI = H_ACT + H_DISP - 1 - PIX_LAT;
    localparam logic [CNT_W-1:0] REQ_X0   = CNT_W'(REQ_H_LO);
    localparam logic [CNT_W-1:0] REQ_Y0   = CNT_W'(V_ACT);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic v_win;
    logic h_req_win;
    logic h_de_win;
    logic hs_raw;
    logic vs_raw;
    logic de_raw;
    logic req;

    vga_timing_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_cnt (
        .pixel_clk (pixel_clk),
        .sys_rst   (sys_rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt)
    );

    always_comb begin
        v_win     = in_range(v_cnt, V_ACT, V_ACT + V_DISP - 1);
        h_req_win = in_range(h_cnt, REQ_H_LO, REQ_H_HI);
        h_de_win  = in_range(h_cnt, H_ACT, H_ACT + H_DISP - 1);
        hs_raw    = int'(h_cnt) < H_SYNC;
        vs_raw    = int'(v_cnt) < V_SYNC;
        de_raw    = h_de_win && v_win;
        // Gated by reset so the request path is quiet even before the
        // counters have seen their first reset edge.
        req       = h_req_win && v_win && !sys_rst;
    end

    // Subtractions are only exposed inside the window, so they never wrap.
    assign vif.data_req   = req;
    assign vif.pixel_xpos = req ? (h_cnt - REQ_X0) : '0;
    assign vif.pixel_ypos = req ? (v_cnt - REQ_Y0) : '0;

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            vif.vga_hs      <= ~H_POL;
            vif.vga_vs      <= ~V_POL;
            vif.vga_de      <= 1'b0;
            vif.vga_rgb     <= RGB_BLACK;
            vif.frame_start <= 1'b0;
        end else begin
            vif.vga_hs      <= hs_raw ? H_POL : ~H_POL;
            vif.vga_vs      <= vs_raw ? V_POL : ~V_POL;
            vif.vga_de      <= de_raw;
            vif.vga_rgb     <= de_raw ? vif.pixel_data : RGB_BLACK;
            vif.frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_driver.sv
// tb/tb_vga_driver.sv - directed self-checking bench for vga_driver
module tb_vga_driver;

    localparam int S_HS = 4,  S_HB = 6, S_HD = 16, S_HF = 4;
    localparam int S_VS = 2,  S_VB = 3, S_VD = 5,  S_VF = 2;
    localparam int S_HT = S_HS + S_HB + S_HD + S_HF;
    localparam int S_VT = S_VS + S_VB + S_VD + S_VF;
    localparam int S_HACT = S_HS + S_HB;
    localparam int S_VACT = S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   st = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_driver_if if_hd ();
    vga_driver_if if_l1 ();
    vga_driver_if if_l3 ();

    vga_driver u_hd (
        .pixel_clk (clk),
        .sys_rst   (rst),
        .vif       (if_hd)
    );

    vga_driver #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF),
        .H_POL(1'b1), .V_POL(1'b1), .PIX_LAT(1)
    ) u_l1 (
        .pixel_clk (clk),
        .sys_rst   (rst),
        .vif       (if_l1)
    );

    vga_driver #(
        .H_SYNC(S_HS), .H_BACK(S_HB), .H_DISP(S_HD), .H_FRONT(S_HF),
        .V_SYNC(S_VS), .V_BACK(S_VB), .V_DISP(S_VD), .V_FRONT(S_VF),
        .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(3)
    ) u_l3 (
        .pixel_clk (clk),
        .sys_rst   (rst),
        .vif       (if_l3)
    );

    // Pixel-source models: colour = column mod 64, with 1 or 3 stages of latency.
    logic [5:0] p3_a, p3_b;
    always @(posedge clk) begin
        if_hd.pixel_data <= if_hd.pixel_xpos[5:0];
        if_l1.pixel_data <= if_l1.pixel_xpos[5:0];
        p3_a             <= if_l3.pixel_xpos[5:0];
        p3_b             <= p3_a;
        if_l3.pixel_data <= p3_b;
    end

    // Registered outputs after clock edge s reflect counter state s:
    // {hs, vs, de, rgb[5:0], frame_start}
    function automatic logic [9:0] exp_regs(int s, bit hpol, bit vpol);
        int   h = s % S_HT;
        int   v = (s / S_HT) % S_VT;
        logic de;
        de = (h >= S_HACT) && (h < S_HACT + S_HD) && (v >= S_VACT) && (v < S_VACT + S_VD);
        return {(h < S_HS) ? hpol : ~hpol, (v < S_VS) ? vpol : ~vpol, de,
                de ? 6'(h - S_HACT) : 6'd0, (h == 0) && (v == 0)};
    endfunction

    // Combinational request outputs after edge s reflect counter state s+1:
    // {data_req, pixel_xpos, pixel_ypos}
    function automatic logic [22:0] exp_req(int s, int lat);
        int   n = (s + 1) % S_FRAME;
        int   h = n % S_HT;
        int   v = n / S_HT;
        logic r;
        r = (h >= S_HACT - lat) && (h <= S_HACT + S_HD - 1 - lat) &&
            (v >= S_VACT) && (v < S_VACT + S_VD);
        return {r, r ? 11'(h - (S_HACT - lat)) : 11'd0, r ? 11'(v - S_VACT) : 11'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        st++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) step();
        checks += 9;
        if (if_hd.vga_hs !== 1'b0) begin errors++; $display("FAIL reset_hs: got %b expected 0", if_hd.vga_hs); end
        if (if_hd.vga_vs !== 1'b0) begin errors++; $display("FAIL reset_vs: got %b expected 0", if_hd.vga_vs); end
        if (if_hd.vga_de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b expected 0", if_hd.vga_de); end
        if (if_hd.vga_rgb !== 6'd0) begin errors++; $display("FAIL reset_rgb: got %h expected 0", if_hd.vga_rgb); end
        if (if_hd.data_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", if_hd.data_req); end
        if (if_hd.pixel_xpos !== 11'd0) begin errors++; $display("FAIL reset_xpos: got %0d expected 0", if_hd.pixel_xpos); end
        if (if_hd.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b expected 0", if_hd.frame_start); end
        if (if_l3.vga_hs !== 1'b1) begin errors++; $display("FAIL reset_hs_lowpol: got %b expected 1", if_l3.vga_hs); end
        if (if_l3.vga_vs !== 1'b1) begin errors++; $display("FAIL reset_vs_lowpol: got %b expected 1", if_l3.vga_vs); end
        rst = 1'b0;
        st  = -1;
        step();
        checks += 5;
        if (if_hd.frame_start !== 1'b1) begin errors++; $display("FAIL release_fs_hd: got %b expected 1", if_hd.frame_start); end
        if (if_l1.frame_start !== 1'b1) begin errors++; $display("FAIL release_fs_l1: got %b expected 1", if_l1.frame_start); end
        if (if_l3.frame_start !== 1'b1) begin errors++; $display("FAIL release_fs_l3: got %b expected 1", if_l3.frame_start); end
        if (if_hd.vga_hs !== 1'b1) begin errors++; $display("FAIL release_hs_hd: got %b expected 1", if_hd.vga_hs); end
        if (if_l3.vga_hs !== 1'b0) begin errors++; $display("FAIL release_hs_l3: got %b expected 0", if_l3.vga_hs); end
    endtask

    task automatic test_hd_hsync();
        int highs = 0, vs_highs = 0, de_highs = 0, reqs = 0;
        int rise1 = -1, rise2 = -1;
        logic prev = 1'b0;
        forever begin
            if (if_hd.vga_hs && !prev) begin
                if (rise1 < 0) rise1 = st;
                else if (rise2 < 0) rise2 = st;
            end
            highs    += int'(if_hd.vga_hs);
            vs_highs += int'(if_hd.vga_vs);
            de_highs += int'(if_hd.vga_de);
            reqs     += int'(if_hd.data_req);
            prev = if_hd.vga_hs;
            if (st >= 3299) break;
            step();
        end
        checks += 6;
        if (highs !== 80) begin errors++; $display("FAIL hd_hs_width: got %0d expected 80", highs); end
        if (rise1 !== 0) begin errors++; $display("FAIL hd_hs_rise1: got %0d expected 0", rise1); end
        if (rise2 !== 1650) begin errors++; $display("FAIL hd_hs_period: got %0d expected 1650", rise2); end
        if (vs_highs !== 3300) begin errors++; $display("FAIL hd_vs_sync_lines: got %0d expected 3300", vs_highs); end
        if (de_highs !== 0) begin errors++; $display("FAIL hd_de_in_sync: got %0d expected 0", de_highs); end
        if (reqs !== 0) begin errors++; $display("FAIL hd_req_in_sync: got %0d expected 0", reqs); end
    endtask

    task automatic test_raster_l1();
        logic [9:0]  got_r;
        logic [22:0] got_q;
        repeat (2 * S_FRAME) begin
            step();
            got_r = {if_l1.vga_hs, if_l1.vga_vs, if_l1.vga_de, if_l1.vga_rgb, if_l1.frame_start};
            got_q = {if_l1.data_req, if_l1.pixel_xpos, if_l1.pixel_ypos};
            checks += 2;
            if (got_r !== exp_regs(st, 1'b1, 1'b1)) begin
                errors++; $display("FAIL raster_l1_regs st=%0d: got %h expected %h", st, got_r, exp_regs(st, 1'b1, 1'b1));
            end
            if (got_q !== exp_req(st, 1)) begin
                errors++; $display("FAIL raster_l1_req st=%0d: got %h expected %h", st, got_q, exp_req(st, 1));
            end
        end
    endtask

    task automatic test_raster_l3();
        logic [9:0]  got_r;
        logic [22:0] got_q;
        repeat (2 * S_FRAME) begin
            step();
            got_r = {if_l3.vga_hs, if_l3.vga_vs, if_l3.vga_de, if_l3.vga_rgb, if_l3.frame_start};
            got_q = {if_l3.data_req, if_l3.pixel_xpos, if_l3.pixel_ypos};
            checks += 2;
            if (got_r !== exp_regs(st, 1'b0, 1'b0)) begin
                errors++; $display("FAIL raster_l3_regs st=%0d: got %h expected %h", st, got_r, exp_regs(st, 1'b0, 1'b0));
            end
            if (got_q !== exp_req(st, 3)) begin
                errors++; $display("FAIL raster_l3_req st=%0d: got %h expected %h", st, got_q, exp_req(st, 3));
            end
        end
    endtask

    // 720p: first request at h=259 v=25, last at h=1538, 1280 active pixels on line 25.
    task automatic test_hd_request();
        int de_cnt = 0;
        while (st < 41507) step();
        checks++;
        if (if_hd.data_req !== 1'b0) begin errors++; $display("FAIL hd_req_before: got %b expected 0", if_hd.data_req); end
        step();
        checks += 3;
        if (if_hd.data_req !== 1'b1) begin errors++; $display("FAIL hd_req_first: got %b expected 1", if_hd.data_req); end
        if (if_hd.pixel_xpos !== 11'd0) begin errors++; $display("FAIL hd_xpos_first: got %0d expected 0", if_hd.pixel_xpos); end
        if (if_hd.pixel_ypos !== 11'd0) begin errors++; $display("FAIL hd_ypos_first: got %0d expected 0", if_hd.pixel_ypos); end
        while (st < 43157) begin
            step();
            de_cnt += int'(if_hd.vga_de);
            if (st == 41510) begin
                checks++;
                if ({if_hd.vga_de, if_hd.vga_rgb} !== 7'h40) begin
                    errors++; $display("FAIL hd_first_pixel: got %h expected 40", {if_hd.vga_de, if_hd.vga_rgb});
                end
            end
            if (st == 41511) begin
                checks++;
                if (if_hd.vga_rgb !== 6'd1) begin errors++; $display("FAIL hd_second_pixel: got %0d expected 1", if_hd.vga_rgb); end
            end
            if (st == 42787) begin
                checks++;
                if ({if_hd.data_req, if_hd.pixel_xpos} !== {1'b1, 11'd1279}) begin
                    errors++; $display("FAIL hd_req_last: got %b/%0d expected 1/1279", if_hd.data_req, if_hd.pixel_xpos);
                end
            end
            if (st == 42788) begin
                checks++;
                if (if_hd.data_req !== 1'b0) begin errors++; $display("FAIL hd_req_after: got %b expected 0", if_hd.data_req); end
            end
        end
        checks++;
        if (de_cnt !== 1280) begin errors++; $display("FAIL hd_de_count: got %0d expected 1280", de_cnt); end
    endtask

    // Reset while l1 is requesting line 7 column 15, then check one clean frame.
    task automatic test_midframe_reset();
        logic [9:0] got_r;
        while (((st + 1) % S_FRAME) != 7 * S_HT + 15) step();
        checks++;
        if ({if_l1.data_req, if_l1.pixel_xpos, if_l1.pixel_ypos} !== {1'b1, 11'd6, 11'd2}) begin
            errors++; $display("FAIL mid_req_before: got %h expected %h",
                               {if_l1.data_req, if_l1.pixel_xpos, if_l1.pixel_ypos}, {1'b1, 11'd6, 11'd2});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({if_l1.data_req, if_l1.pixel_xpos} !== 12'd0) begin
            errors++; $display("FAIL mid_req_in_reset: got %h expected 0", {if_l1.data_req, if_l1.pixel_xpos});
        end
        step();
        checks += 3;
        if ({if_l1.vga_hs, if_l1.vga_vs, if_l1.vga_de, if_l1.vga_rgb, if_l1.frame_start} !== 10'd0) begin
            errors++; $display("FAIL mid_l1_regs: got %h expected 0",
                               {if_l1.vga_hs, if_l1.vga_vs, if_l1.vga_de, if_l1.vga_rgb, if_l1.frame_start});
        end
        if ({if_l3.vga_hs, if_l3.vga_vs, if_l3.vga_de} !== 3'b110) begin
            errors++; $display("FAIL mid_l3_regs: got %b expected 110", {if_l3.vga_hs, if_l3.vga_vs, if_l3.vga_de});
        end
        if ({if_hd.vga_de, if_hd.vga_rgb, if_hd.data_req} !== 8'd0) begin
            errors++; $display("FAIL mid_hd_regs: got %h expected 0", {if_hd.vga_de, if_hd.vga_rgb, if_hd.data_req});
        end
        rst = 1'b0;
        st  = -1;
        repeat (S_FRAME) begin
            step();
            got_r = {if_l1.vga_hs, if_l1.vga_vs, if_l1.vga_de, if_l1.vga_rgb, if_l1.frame_start};
            checks++;
            if (got_r !== exp_regs(st, 1'b1, 1'b1)) begin
                errors++; $display("FAIL restart_l1 st=%0d: got %h expected %h", st, got_r, exp_regs(st, 1'b1, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_hd_hsync();
        test_raster_l1();
        test_raster_l3();
        test_hd_request();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
